// File: rtl/majority_vote_sched_pkg.sv
// Shared types and constants for the majority-vote scheduler.
// Holds the FSM state encoding, vote width, voting threshold and a popcount helper.
package majority_vote_sched_pkg;

  localparam int VOTE_W     = 5;
  localparam int MAJ_THRESH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    EVAL  = 2'd2,
    ACK   = 2'd3
  } state_t;

  function automatic logic [2:0] popcnt5(input logic [VOTE_W-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < VOTE_W; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/majority_vote_sched_if.sv
// Requester-side bus of the majority-vote scheduler: req/votes in, ack and result out.
// MAJ_SCHED_POPCNT_EN adds the vote_cnt output.
interface majority_vote_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*5-1:0] votes;
  logic [NREQ-1:0]   ack;
  logic              busy;
  logic              valid;
  logic              result;
  logic [IDW-1:0]    result_id;
`ifdef MAJ_SCHED_POPCNT_EN
  logic [2:0]        vote_cnt;

  modport master (output req, votes,
                  input  ack, busy, valid, result, result_id, vote_cnt);
  modport slave  (input  req, votes,
                  output ack, busy, valid, result, result_id, vote_cnt);
`else
  modport master (output req, votes,
                  input  ack, busy, valid, result, result_id);
  modport slave  (input  req, votes,
                  output ack, busy, valid, result, result_id);
`endif
endinterface

// File: rtl/majority.sv
// Combinational 5-input majority voter: z1 is high when at least three inputs are high.
module majority (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic x5,
  output logic z1
);
  logic [2:0] cnt;

  assign cnt = {2'b00, x1} + {2'b00, x2} + {2'b00, x3} + {2'b00, x4} + {2'b00, x5};
  assign z1  = (cnt >= 3'd3);
endmodule

// File: rtl/majority_vote_sched_rr_arbiter.sv
// Round-robin arbiter: first active request found searching upward from ptr, wrapping at NREQ-1.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  int c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IDW'(c);
      end
    end
  end
endmodule

// File: rtl/majority_vote_sched.sv
// Time-shares one majority voter among NREQ requesters with round-robin arbitration.
// Optional MAJ_SCHED_POPCNT_EN registers the popcount of the latched vote as vote_cnt.
//
//   state | meaning
//   IDLE  | wait for any req, capture round-robin winner
//   LATCH | copy winner's votes into the voter register
//   EVAL  | register voter output and winner id
//   ACK   | ack/valid pulse, advance round-robin pointer
module majority_vote_sched
  import majority_vote_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  majority_vote_sched_if.slave bus
);

  state_t              state_q, state_d;
  logic [IDW-1:0]      winner_q, ptr_q, ptr_nxt, grant_idx, result_id_q;
  logic [NREQ-1:0]     grant, grant_q, ack_q;
  logic                grant_any;
  logic [VOTE_W-1:0]   vote_q;
  logic [VOTE_W-1:0]   vote_arr [NREQ];
  logic                z1, result_q, valid_q;
`ifdef MAJ_SCHED_POPCNT_EN
  logic [2:0]          vote_cnt_q;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_votes
    assign vote_arr[i] = bus.votes[VOTE_W*i +: VOTE_W];
  end

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Bit 4 of the vote vector is x1, bit 0 is x5.
  majority u_vote (
    .x1 (vote_q[4]),
    .x2 (vote_q[3]),
    .x3 (vote_q[2]),
    .x4 (vote_q[1]),
    .x5 (vote_q[0]),
    .z1 (z1)
  );

  assign ptr_nxt = (winner_q == IDW'(NREQ-1)) ? '0 : winner_q + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = LATCH;
      LATCH:   state_d = EVAL;
      EVAL:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ack/valid are loaded on the EVAL->ACK edge so they are flop outputs, high only in ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner_q    <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
      vote_q      <= '0;
      result_q    <= 1'b0;
      result_id_q <= '0;
      ack_q       <= '0;
      valid_q     <= 1'b0;
`ifdef MAJ_SCHED_POPCNT_EN
      vote_cnt_q  <= '0;
`endif
    end else begin
      ack_q   <= '0;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            winner_q <= grant_idx;
            grant_q  <= grant;
          end
        end
        LATCH: vote_q <= vote_arr[winner_q];
        EVAL: begin
          result_q    <= z1;
          result_id_q <= winner_q;
          ack_q       <= grant_q;
          valid_q     <= 1'b1;
`ifdef MAJ_SCHED_POPCNT_EN
          vote_cnt_q  <= popcnt5(vote_q);
`endif
        end
        ACK:     ptr_q <= ptr_nxt;
        default: ;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;
  assign bus.result_id = result_id_q;
`ifdef MAJ_SCHED_POPCNT_EN
  assign bus.vote_cnt  = vote_cnt_q;
`endif

endmodule

// File: tb/tb_majority_vote_sched.sv
// Directed bench for majority_vote_sched: reset, single/multi requester service, vote sweep,
// late vote change and mid-transaction reset. Define MAJ_SCHED_POPCNT_EN to also check vote_cnt.
module tb_majority_vote_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  int   cyc;

  majority_vote_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  majority_vote_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until valid is seen; a missing valid is itself a failed check.
  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.valid && cycles < 20);
    if (cycles >= 20) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  {31'd0, bus.busy},  32'd0);
    chk({tag, "_valid"}, {31'd0, bus.valid}, 32'd0);
    chk({tag, "_ack"},   {28'd0, bus.ack},   32'd0);
  endtask

  initial begin
    logic [4:0] v;
    int         exp_id;
    logic       exp_res;
    total     = 0;
    passed    = 0;
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.votes = '0;

    // Reset and a quiet period
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");
    chk("rst_result",    {31'd0, bus.result},    32'd0);
    chk("rst_result_id", {30'd0, bus.result_id}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_idle_outputs("quiet");
    end
    chk("quiet_result", {31'd0, bus.result}, 32'd0);

    // Single requester 0, votes 10110
    bus.votes[4:0] = 5'b10110;
    bus.req        = 4'b0001;
    wait_valid("r0", cyc);
    chk("r0_latency", cyc,                        32'd3);
    chk("r0_ack",     {28'd0, bus.ack},           32'h1);
    chk("r0_result",  {31'd0, bus.result},        32'd1);
    chk("r0_id",      {30'd0, bus.result_id},     32'd0);
`ifdef MAJ_SCHED_POPCNT_EN
    chk("r0_cnt",     {29'd0, bus.vote_cnt},      32'd3);
`endif
    bus.req = '0;
    @(negedge clk);
    chk("r0_ack_pulse",   {28'd0, bus.ack},   32'h0);
    chk("r0_valid_pulse", {31'd0, bus.valid}, 32'd0);
    chk("r0_hold",        {31'd0, bus.result}, 32'd1);

    // Requester 2, votes 10010
    bus.votes[14:10] = 5'b10010;
    bus.req          = 4'b0100;
    wait_valid("r2", cyc);
    chk("r2_latency", cyc,                    32'd3);
    chk("r2_ack",     {28'd0, bus.ack},       32'h4);
    chk("r2_result",  {31'd0, bus.result},    32'd0);
    chk("r2_id",      {30'd0, bus.result_id}, 32'd2);
`ifdef MAJ_SCHED_POPCNT_EN
    chk("r2_cnt",     {29'd0, bus.vote_cnt},  32'd2);
`endif
    bus.req = '0;
    @(negedge clk);

    // Sweep all 32 vote vectors on requester 1
    for (int k = 0; k < 32; k++) begin
      v              = 5'(k);
      exp_res        = ($countones(v) >= 3);
      bus.votes[9:5] = v;
      bus.req        = 4'b0010;
      wait_valid("sweep", cyc);
      chk("sweep_result", {31'd0, bus.result},    {31'd0, exp_res});
      chk("sweep_id",     {30'd0, bus.result_id}, 32'd1);
`ifdef MAJ_SCHED_POPCNT_EN
      chk("sweep_cnt",    {29'd0, bus.vote_cnt},  32'($countones(v)));
`endif
      bus.req = '0;
      @(negedge clk);
    end

    // All four requesters held from reset: 0,1,2,3,0,1, one ack per 4 cycles
    rst_n = 1'b0;
    @(negedge clk);
    bus.votes = {5'b01111, 5'b11000, 5'b00000, 5'b11111};
    bus.req   = 4'b1111;
    rst_n     = 1'b1;
    for (int t = 0; t < 6; t++) begin
      exp_id = t % 4;
      exp_res = (exp_id == 0 || exp_id == 3);
      wait_valid("rr", cyc);
      chk("rr_spacing", cyc, (t == 0) ? 32'd3 : 32'd4);
      chk("rr_ack",     {28'd0, bus.ack},       32'(1 << exp_id));
      chk("rr_id",      {30'd0, bus.result_id}, 32'(exp_id));
      chk("rr_result",  {31'd0, bus.result},    {31'd0, exp_res});
    end
    bus.req = '0;
    @(negedge clk);

    // Votes change during EVAL: only the LATCH sample counts
    rst_n = 1'b0;
    @(negedge clk);
    rst_n          = 1'b1;
    bus.votes      = '0;
    bus.votes[9:5] = 5'b11100;
    bus.req        = 4'b0010;
    @(negedge clk);
    chk("late_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.votes[9:5] = 5'b00000;
    @(negedge clk);
    chk("late_valid",  {31'd0, bus.valid},     32'd1);
    chk("late_result", {31'd0, bus.result},    32'd1);
    chk("late_id",     {30'd0, bus.result_id}, 32'd1);
    bus.req = '0;
    @(negedge clk);

    // Reset asserted during EVAL with requester 3 active
    bus.votes[19:15] = 5'b00111;
    bus.req          = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_rst");
    chk("mid_rst_result", {31'd0, bus.result}, 32'd0);
    chk("mid_rst_id",     {30'd0, bus.result_id}, 32'd0);
    @(negedge clk);
    chk_idle_outputs("mid_rst_hold");
    rst_n = 1'b1;
    wait_valid("post_rst", cyc);
    chk("post_rst_latency", cyc,                    32'd3);
    chk("post_rst_ack",     {28'd0, bus.ack},       32'h8);
    chk("post_rst_id",      {30'd0, bus.result_id}, 32'd3);
    chk("post_rst_result",  {31'd0, bus.result},    32'd1);
    bus.req = '0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
